uart_rx: RTL and testbench

- Asynchronous receive half of the pic16f-antastic USART: RCSTA register, RSR shift/sampling engine, 2-deep RCREG FIFO.
- Consumes the far-end transmit line (UART_RXD) and the 16x sample strobe from the shared baud generator.
- Delivers bytes to the register file plus the RCIF set strobe.
- Instantiated in the uart top alongside the transmit logic.

---
 rtl/uart_pkg.sv | 41 ++++
 rtl/uart_rx_fifo.sv | 60 ++++++
 rtl/uart_rx.sv | 175 +++++++++++++++++
 tb/tb_uart_rx.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the USART receive path: RCSTA bit positions,
// receiver state encodings, receive FIFO entry layout and sampling helpers.
package uart_pkg;

  // RCSTA bit positions
  localparam int RCSTA_SPEN  = 7;
  localparam int RCSTA_RX9   = 6;
  localparam int RCSTA_SREN  = 5;
  localparam int RCSTA_CREN  = 4;
  localparam int RCSTA_ADDEN = 3;
  localparam int RCSTA_FERR  = 2;
  localparam int RCSTA_OERR  = 1;
  localparam int RCSTA_RX9D  = 0;

  // Receiver state encodings
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_BIT9  = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;

  // One receive FIFO entry: {ferr, bit9, data}
  localparam int FIFO_ENTRY_W = 10;

  typedef struct packed {
    logic       ferr;
    logic       bit9;
    logic [7:0] data;
  } rx_entry_t;

  // Mid-bit sample index k (0..2) for a given oversample ratio; 7/8/9 at 16x
  function automatic int mid_sample(input int oversample, input int k);
    return oversample / 2 - 1 + k;
  endfunction

  // Two-out-of-three vote over the mid-bit samples
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Two-entry receive FIFO. Slot 0 is always the head; when the FIFO drains
// it keeps the last popped entry, so the data bus holds its value.
// A push together with a pop on a full FIFO is accepted (pop happens first).
module uart_rx_fifo
  import uart_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [FIFO_ENTRY_W-1:0] push_data,
  input  logic                    pop,
  output logic [FIFO_ENTRY_W-1:0] head,
  output logic                    full,
  output logic                    empty
);

  logic [FIFO_ENTRY_W-1:0] slot0;
  logic [FIFO_ENTRY_W-1:0] slot1;
  logic [1:0]              count;
  logic                    do_pop;
  logic                    do_push;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);

  // Shift-style storage update: pops move slot 1 forward, pushes fill the next free slot
  always_ff @(posedge clk) begin
    if (rst) begin
      slot0 <= '0;
      slot1 <= '0;
      count <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b01: begin
          if (count == 2'd2) slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b10: begin
          if (count == 2'd0) slot0 <= push_data;
          else               slot1 <= push_data;
          count <= count + 2'd1;
        end
        2'b11: begin
          if (count == 2'd2) begin
            slot0 <= slot1;
            slot1 <= push_data;
          end else begin
            slot0 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head  = slot0;
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

endmodule

// File: rtl/uart_rx.sv
// USART asynchronous receiver: RCSTA control/status, oversampled start/data/
// stop recovery with 3-sample majority voting, and the 2-deep RCREG FIFO.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       UART_RXD,
  input  logic       rx_sample_en,
  input  logic [7:0] reg_data_in,
  input  logic       rcsta_reg_wr_en,
  output logic [7:0] rcsta_reg_out,
  input  logic       rcreg_rd_en,
  output logic [7:0] rcreg_reg_out,
  output logic       rxif_set_en
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] SMP_A    = CNT_W'(mid_sample(OVERSAMPLE, 0));
  localparam logic [CNT_W-1:0] SMP_B    = CNT_W'(mid_sample(OVERSAMPLE, 1));
  localparam logic [CNT_W-1:0] SMP_C    = CNT_W'(mid_sample(OVERSAMPLE, 2));
  localparam logic [CNT_W-1:0] SMP_LAST = CNT_W'(OVERSAMPLE - 1);

  logic             spen, rx9, cren, adden, oerr;
  logic             rxd_meta, rxd_sync;
  logic [2:0]       state;
  logic [CNT_W-1:0] sample_cnt;
  logic [2:0]       bit_cnt;
  logic             smp_a, smp_b;
  logic [7:0]       rsr;
  logic             rsr_bit9;
  logic             vote;
  logic             rx_enabled;
  logic             push;
  logic             overflow;
  rx_entry_t        push_entry;
  rx_entry_t        head_entry;
  logic             fifo_full, fifo_empty;
  logic             unused_wr_bits;

  assign rx_enabled = spen & cren;
  assign vote       = majority3(smp_a, smp_b, rxd_sync);

  assign push_entry.ferr = ~vote;
  assign push_entry.bit9 = rx9 ? rsr_bit9 : 1'b0;
  assign push_entry.data = rsr;

  // Push at the stop-bit decision unless address mode filters a data byte out
  assign push = rx_sample_en && rx_enabled && (state == ST_STOP) && (sample_cnt == SMP_C) &&
                !(rx9 && adden && !push_entry.bit9);
  assign overflow = push && fifo_full && !rcreg_rd_en;

  assign unused_wr_bits = ^{reg_data_in[RCSTA_SREN], reg_data_in[RCSTA_FERR],
                            reg_data_in[RCSTA_OERR], reg_data_in[RCSTA_RX9D]};

  // Two-flop synchronizer for the asynchronous line, idling high
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
    end else begin
      rxd_meta <= UART_RXD;
      rxd_sync <= rxd_meta;
    end
  end

  // Software-writable RCSTA control bits
  always_ff @(posedge clk) begin
    if (rst) begin
      spen  <= 1'b0;
      rx9   <= 1'b0;
      cren  <= 1'b0;
      adden <= 1'b0;
    end else if (rcsta_reg_wr_en) begin
      spen  <= reg_data_in[RCSTA_SPEN];
      rx9   <= reg_data_in[RCSTA_RX9];
      cren  <= reg_data_in[RCSTA_CREN];
      adden <= reg_data_in[RCSTA_ADDEN];
    end
  end

  // Overrun flag: set when a byte arrives with the FIFO full, cleared by writing CREN=0
  always_ff @(posedge clk) begin
    if (rst) begin
      oerr <= 1'b0;
    end else if (rcsta_reg_wr_en && !reg_data_in[RCSTA_CREN]) begin
      oerr <= 1'b0;
    end else if (overflow) begin
      oerr <= 1'b1;
    end
  end

  // Frame recovery FSM; disabling the receiver drops any frame in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      sample_cnt <= '0;
      bit_cnt    <= 3'd0;
      smp_a      <= 1'b1;
      smp_b      <= 1'b1;
      rsr        <= 8'h00;
      rsr_bit9   <= 1'b0;
    end else if (!rx_enabled) begin
      state <= ST_IDLE;
    end else if (rx_sample_en) begin
      if (state != ST_IDLE) begin
        sample_cnt <= sample_cnt + 1'b1;
        if (sample_cnt == SMP_A) smp_a <= rxd_sync;
        if (sample_cnt == SMP_B) smp_b <= rxd_sync;
      end
      case (state)
        ST_IDLE: begin
          if (!oerr && !rxd_sync) begin
            state      <= ST_START;
            sample_cnt <= '0;
            rsr_bit9   <= 1'b0;
          end
        end
        ST_START: begin
          if (sample_cnt == SMP_C && vote) begin
            state <= ST_IDLE;
          end else if (sample_cnt == SMP_LAST) begin
            state   <= ST_DATA;
            bit_cnt <= 3'd0;
          end
        end
        ST_DATA: begin
          if (sample_cnt == SMP_C) rsr <= {vote, rsr[7:1]};
          if (sample_cnt == SMP_LAST) begin
            if (bit_cnt == 3'd7) state <= rx9 ? ST_BIT9 : ST_STOP;
            else                 bit_cnt <= bit_cnt + 3'd1;
          end
        end
        ST_BIT9: begin
          if (sample_cnt == SMP_C)    rsr_bit9 <= vote;
          if (sample_cnt == SMP_LAST) state    <= ST_STOP;
        end
        ST_STOP: begin
          if (sample_cnt == SMP_C) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  uart_rx_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (rcreg_rd_en),
    .head      (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // RCSTA readback; FERR and RX9D follow the head entry and read 0 when empty
  always_comb begin
    rcsta_reg_out              = 8'h00;
    rcsta_reg_out[RCSTA_SPEN]  = spen;
    rcsta_reg_out[RCSTA_RX9]   = rx9;
    rcsta_reg_out[RCSTA_SREN]  = 1'b0;
    rcsta_reg_out[RCSTA_CREN]  = cren;
    rcsta_reg_out[RCSTA_ADDEN] = adden;
    rcsta_reg_out[RCSTA_FERR]  = head_entry.ferr & ~fifo_empty;
    rcsta_reg_out[RCSTA_OERR]  = oerr;
    rcsta_reg_out[RCSTA_RX9D]  = head_entry.bit9 & ~fifo_empty;
  end

  assign rcreg_reg_out = head_entry.data;
  assign rxif_set_en   = ~fifo_empty;

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: directed frames at 16 clocks per bit with a
// queue-based model of RCSTA/RCREG compared on every quiet cycle.
module tb_uart_rx;

  logic       clk;
  logic       rst;
  logic       UART_RXD;
  logic       rx_sample_en;
  logic [7:0] reg_data_in;
  logic       rcsta_reg_wr_en;
  logic [7:0] rcsta_reg_out;
  logic       rcreg_rd_en;
  logic [7:0] rcreg_reg_out;
  logic       rxif_set_en;

  int vec_count = 0;
  int err_count = 0;
  bit check_en  = 0;

  // Model state
  logic [9:0] m_q[$];
  logic       m_spen, m_rx9, m_cren, m_adden, m_oerr;
  logic [7:0] m_last;

  uart_rx #(.OVERSAMPLE(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .UART_RXD        (UART_RXD),
    .rx_sample_en    (rx_sample_en),
    .reg_data_in     (reg_data_in),
    .rcsta_reg_wr_en (rcsta_reg_wr_en),
    .rcsta_reg_out   (rcsta_reg_out),
    .rcreg_rd_en     (rcreg_rd_en),
    .rcreg_reg_out   (rcreg_reg_out),
    .rxif_set_en     (rxif_set_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    vec_count++;
    if (actual !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: got %02h, expected %02h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [7:0] exp_rcsta();
    logic [9:0] h;
    h = (m_q.size() != 0) ? m_q[0] : 10'h000;
    return {m_spen, m_rx9, 1'b0, m_cren, m_adden, h[9], m_oerr, h[8]};
  endfunction

  function automatic logic [7:0] exp_rcreg();
    logic [9:0] h;
    if (m_q.size() == 0) return m_last;
    h = m_q[0];
    return h[7:0];
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_spen  = 1'b0;
    m_rx9   = 1'b0;
    m_cren  = 1'b0;
    m_adden = 1'b0;
    m_oerr  = 1'b0;
    m_last  = 8'h00;
  endtask

  task automatic model_pop();
    logic [9:0] h;
    if (m_q.size() != 0) begin
      h = m_q.pop_front();
      m_last = h[7:0];
    end
  endtask

  task automatic model_frame(input logic [7:0] d, input logic b9, input logic stop_lvl);
    logic [9:0] e;
    if (!(m_spen && m_cren && !m_oerr)) return;
    e = {~stop_lvl, (m_rx9 ? b9 : 1'b0), d};
    if (m_rx9 && m_adden && !e[8]) return;
    if (m_q.size() >= 2) begin
      m_oerr = 1'b1;
      return;
    end
    m_q.push_back(e);
  endtask

  // Compare DUT outputs with the model on every cycle the model is settled
  always @(posedge clk) begin
    #2;
    if (check_en) begin
      checkOutput("rcsta", rcsta_reg_out, exp_rcsta());
      checkOutput("rcreg", rcreg_reg_out, exp_rcreg());
      checkOutput("rxif", {7'b0, rxif_set_en}, {7'b0, (m_q.size() != 0)});
    end
  end

  task automatic do_reset();
    check_en = 0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_en = 1;
  endtask

  task automatic writeRcsta(input logic [7:0] v);
    @(negedge clk);
    check_en        = 0;
    reg_data_in     = v;
    rcsta_reg_wr_en = 1'b1;
    @(negedge clk);
    rcsta_reg_wr_en = 1'b0;
    m_spen  = v[7];
    m_rx9   = v[6];
    m_cren  = v[4];
    m_adden = v[3];
    if (!v[4]) m_oerr = 1'b0;
    check_en = 1;
  endtask

  task automatic readRcreg();
    @(negedge clk);
    check_en    = 0;
    rcreg_rd_en = 1'b1;
    @(negedge clk);
    rcreg_rd_en = 1'b0;
    model_pop();
    check_en = 1;
  endtask

  // Drive one frame; optional glitch cycle, pop cycle, or reset cycle (-1 = none)
  task automatic applyStimulus(input logic [7:0] d, input logic b9, input logic stop_lvl,
                               input int glitch_at, input int pop_at, input int rst_at);
    logic frame [0:10];
    int   nbits;
    int   len;
    check_en = 0;
    nbits    = m_rx9 ? 11 : 10;
    frame[0] = 1'b0;
    for (int i = 0; i < 8; i++) frame[1+i] = d[i];
    frame[10] = 1'b1;
    if (m_rx9) begin
      frame[9]  = b9;
      frame[10] = stop_lvl;
    end else begin
      frame[9] = stop_lvl;
    end
    len = (rst_at >= 0) ? rst_at + 2 : 16 * nbits;
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      if (rst_at >= 0 && c >= rst_at) begin
        UART_RXD = 1'b1;
        rst      = 1'b1;
      end else begin
        UART_RXD = frame[c/16] ^ (c == glitch_at);
      end
      rcreg_rd_en = (c == pop_at);
    end
    @(negedge clk);
    rst         = 1'b0;
    UART_RXD    = 1'b1;
    rcreg_rd_en = 1'b0;
    if (rst_at >= 0) begin
      model_reset();
    end else begin
      if (pop_at >= 0) model_pop();
      model_frame(d, b9, stop_lvl);
    end
    check_en = 1;
    repeat (24) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d);
    applyStimulus(d, 1'b0, 1'b1, -1, -1, -1);
  endtask

  initial begin
    rst             = 1'b1;
    UART_RXD        = 1'b1;
    rx_sample_en    = 1'b1;
    reg_data_in     = 8'h00;
    rcsta_reg_wr_en = 1'b0;
    rcreg_rd_en     = 1'b0;
    model_reset();
    do_reset();
    @(negedge clk);
    checkOutput("reset_rcsta", rcsta_reg_out, 8'h00);
    checkOutput("reset_rcreg", rcreg_reg_out, 8'h00);
    checkOutput("reset_rxif", {7'b0, rxif_set_en}, 8'h00);

    // Read-only bits ignore writes
    writeRcsta(8'hB7);
    @(negedge clk);
    checkOutput("rcsta_ro_bits", rcsta_reg_out, 8'h90);

    // Basic reception and pop
    send(8'h55);
    checkOutput("rx55_data", rcreg_reg_out, 8'h55);
    checkOutput("rx55_rxif", {7'b0, rxif_set_en}, 8'h01);
    checkOutput("rx55_rcsta", rcsta_reg_out, 8'h90);
    readRcreg();
    checkOutput("pop55_rxif", {7'b0, rxif_set_en}, 8'h00);
    readRcreg();
    checkOutput("empty_pop_hold", rcreg_reg_out, 8'h55);

    // Overrun
    send(8'hA1);
    send(8'hB2);
    send(8'hC3);
    checkOutput("oerr_rcsta", rcsta_reg_out, 8'h92);
    checkOutput("oerr_head", rcreg_reg_out, 8'hA1);
    send(8'hDD);
    checkOutput("oerr_ignored", rcreg_reg_out, 8'hA1);
    readRcreg();
    checkOutput("oerr_second", rcreg_reg_out, 8'hB2);
    readRcreg();
    checkOutput("oerr_drained", {7'b0, rxif_set_en}, 8'h00);
    writeRcsta(8'h80);
    @(negedge clk);
    checkOutput("oerr_clear", rcsta_reg_out, 8'h80);
    writeRcsta(8'h90);
    send(8'h3C);
    checkOutput("rx3c_data", rcreg_reg_out, 8'h3C);
    readRcreg();

    // Push and pop in the same cycle on a full FIFO
    send(8'h11);
    send(8'h22);
    applyStimulus(8'h33, 1'b0, 1'b1, -1, 156, -1);
    checkOutput("pushpop_head", rcreg_reg_out, 8'h22);
    checkOutput("pushpop_rcsta", rcsta_reg_out, 8'h90);
    readRcreg();
    checkOutput("pushpop_tail", rcreg_reg_out, 8'h33);
    readRcreg();

    // Framing error
    applyStimulus(8'h7E, 1'b0, 1'b0, -1, -1, -1);
    checkOutput("ferr_data", rcreg_reg_out, 8'h7E);
    checkOutput("ferr_rcsta", rcsta_reg_out, 8'h94);
    readRcreg();
    send(8'h5A);
    checkOutput("ferr_cleared", rcsta_reg_out, 8'h90);
    readRcreg();

    // 9-bit address mode
    writeRcsta(8'hD8);
    applyStimulus(8'h12, 1'b0, 1'b1, -1, -1, -1);
    checkOutput("addr_filtered", {7'b0, rxif_set_en}, 8'h00);
    applyStimulus(8'h34, 1'b1, 1'b1, -1, -1, -1);
    checkOutput("addr_data", rcreg_reg_out, 8'h34);
    checkOutput("addr_rcsta", rcsta_reg_out, 8'hD9);
    readRcreg();
    writeRcsta(8'h90);

    // False start: low for 4 strobes only
    @(negedge clk);
    UART_RXD = 1'b0;
    repeat (4) @(negedge clk);
    UART_RXD = 1'b1;
    repeat (30) @(negedge clk);
    checkOutput("false_start", {7'b0, rxif_set_en}, 8'h00);

    // Glitch on the middle sample of data bit 3
    applyStimulus(8'h00, 1'b0, 1'b1, 73, -1, -1);
    checkOutput("glitch_data", rcreg_reg_out, 8'h00);
    checkOutput("glitch_rxif", {7'b0, rxif_set_en}, 8'h01);

    // Reset at data bit 4 while the FIFO holds an entry
    applyStimulus(8'h99, 1'b0, 1'b1, -1, -1, 80);
    checkOutput("midrst_rcsta", rcsta_reg_out, 8'h00);
    checkOutput("midrst_rxif", {7'b0, rxif_set_en}, 8'h00);
    writeRcsta(8'h90);
    send(8'h99);
    checkOutput("after_rst_data", rcreg_reg_out, 8'h99);
    readRcreg();
    repeat (4) @(negedge clk);

    check_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
